// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative radix-2 Booth multiplier, one Booth step per clock.
// Operands are widened by one bit so signed and unsigned modes share a single
// signed datapath. The accumulator carries one more guard bit, so the
// most-negative and unsigned-max operands never overflow it. A result appears
// WIDTH+1 edges after the accepting start edge. Its timing does not depend on
// the operand values or the mode.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // W1: widened operand width. AW: accumulator width with a guard bit.
  localparam int W1 = WIDTH + 1;
  localparam int AW = W1 + 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Control state (reset)
  logic [0:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic [2*WIDTH-1:0]      r_product;

  // Datapath state (not reset; always reloaded on capture)
  logic signed [W1-1:0]    r_m;
  logic        [W1-1:0]    r_q;
  logic signed [AW-1:0]    r_a;
  logic                    r_qm1;

  // Combinational Booth step
  logic signed [AW-1:0]    w_sum;
  logic signed [AW-1:0]    w_a_next;
  logic        [W1-1:0]    w_q_next;
  logic                    w_qm1_next;
  logic                    w_accept;
  logic                    w_last;

  // Widen an operand by one bit. Sign extension applies in signed mode and
  // zero extension in unsigned mode. Both results are then valid signed values.
  function automatic logic signed [W1-1:0] extend_op(
    input logic [WIDTH-1:0] v,
    input logic             sgn
  );
    logic signed [W1-1:0] r;
    r = {sgn & v[WIDTH-1], v};
    return r;
  endfunction

  // Add, subtract or pass the multiplicand according to the Booth pair
  // {Q[0], q_m1}. All arithmetic is at accumulator width.
  function automatic logic signed [AW-1:0] booth_add(
    input logic signed [AW-1:0] acc,
    input logic signed [W1-1:0] m,
    input logic [1:0]           pair
  );
    logic signed [AW-1:0] m_ext;
    logic signed [AW-1:0] r;
    m_ext = {m[W1-1], m};
    case (pair)
      2'b10:   r = acc - m_ext;
      2'b01:   r = acc + m_ext;
      default: r = acc;
    endcase
    return r;
  endfunction

  // Booth step: conditional add/subtract, then an arithmetic right shift of
  // {A, Q, q_m1} that fills from A's sign bit.
  always_comb begin
    w_sum      = booth_add(r_a, r_m, {r_q[0], r_qm1});
    w_a_next   = {w_sum[AW-1], w_sum[AW-1:1]};
    w_q_next   = {w_sum[0], r_q[W1-1:1]};
    w_qm1_next = r_q[0];
    w_accept   = (r_state == S_IDLE) && start;
    w_last     = (r_cnt == CW'(WIDTH));
  end

  // Control FSM: accept start when idle, count W1 steps, then publish the
  // product and pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // The product fits in 2*WIDTH bits in both modes. The upper bits
            // of {A, Q} are only sign copies.
            r_product <= {w_a_next[WIDTH-2:0], w_q_next};
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: load widened operands on an accepted start, otherwise advance
  // one Booth step per RUN cycle. Inputs are ignored after capture.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_m   <= extend_op(a, is_signed);
      r_q   <= extend_op(b, is_signed);
      r_a   <= '0;
      r_qm1 <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a   <= w_a_next;
      r_q   <= w_q_next;
      r_qm1 <= w_qm1_next;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed testbench for booth_seq_mult, using a WIDTH=4 instance and a
// WIDTH=8 instance that share one clock.
module tb_booth_seq_mult;

  logic clk;
  logic rst;

  logic       start4, sgn4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] prod4;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int n_checks;
  int n_fail;

  booth_seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  booth_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge. Outputs are sampled and inputs are
  // driven 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=4 operation. Return the product and the number of edges
  // from the start edge to done, or -1 if done never arrives.
  task automatic run4(input logic sgn, input logic [3:0] av, input logic [3:0] bv,
                      output logic [7:0] p, output int lat, output int busy_cnt);
    sgn4 = sgn; a4 = av; b4 = bv; start4 = 1'b1;
    step();
    start4 = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      if (busy4) busy_cnt++;
      step();
      if (done4) begin
        lat = i;
        break;
      end
    end
    p = prod4;
  endtask

  task automatic run8(input logic sgn, input logic [7:0] av, input logic [7:0] bv,
                      output logic [15:0] p, output int lat);
    sgn8 = sgn; a8 = av; b8 = bv; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done8) begin
        lat = i;
        break;
      end
    end
    p = prod8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks += 6;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4 got %b want 0", done4); end
    if (prod4 !== 8'h00) begin n_fail++; $display("FAIL reset_prod4 got %h want 00", prod4); end
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got %b want 0", busy8); end
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8 got %b want 0", done8); end
    if (prod8 !== 16'h0000) begin n_fail++; $display("FAIL reset_prod8 got %h want 0000", prod8); end
  endtask

  task automatic test_latency();
    logic [7:0] p;
    int lat, bc;
    run4(1'b1, 4'h8, 4'h8, p, lat, bc);
    n_checks += 5;
    if (lat !== 5) begin n_fail++; $display("FAIL lat_m8m8 got %0d want 5", lat); end
    if (bc !== 5) begin n_fail++; $display("FAIL busy_cycles got %0d want 5", bc); end
    if (p !== 8'h40) begin n_fail++; $display("FAIL prod_m8m8 got %h want 40", p); end
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got %b want 0", busy4); end
    step();
    if (done4 !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", done4); end
  endtask

  task automatic test_directed4();
    logic [7:0] p;
    int lat, bc;
    logic       tsgn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] ta   [4] = '{4'h7, 4'h3, 4'hF, 4'h0};
    logic [3:0] tb   [4] = '{4'h8, 4'hB, 4'hF, 4'h9};
    logic [7:0] texp [4] = '{8'hC8, 8'hF1, 8'hE1, 8'h00};
    for (int i = 0; i < 4; i++) begin
      run4(tsgn[i], ta[i], tb[i], p, lat, bc);
      n_checks += 2;
      if (p !== texp[i]) begin n_fail++; $display("FAIL dir4_%0d got %h want %h", i, p, texp[i]); end
      if (lat !== 5) begin n_fail++; $display("FAIL dir4_lat_%0d got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_width8();
    logic [15:0] p;
    int lat;
    logic        tsgn [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0]  ta   [5] = '{8'h80, 8'hFF, 8'hFF, 8'h7F, 8'hC8};
    logic [7:0]  tb   [5] = '{8'h80, 8'hFF, 8'h01, 8'h80, 8'h03};
    logic [15:0] texp [5] = '{16'h4000, 16'hFE01, 16'hFFFF, 16'hC080, 16'h0258};
    for (int i = 0; i < 5; i++) begin
      run8(tsgn[i], ta[i], tb[i], p, lat);
      n_checks += 2;
      if (p !== texp[i]) begin n_fail++; $display("FAIL w8_%0d got %h want %h", i, p, texp[i]); end
      if (lat !== 9) begin n_fail++; $display("FAIL w8_lat_%0d got %0d want 9", i, lat); end
    end
  endtask

  task automatic test_exhaustive4();
    logic [7:0] p, exp;
    int lat, bc, sa, sb;
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          sa = (s == 1 && ia >= 8) ? ia - 16 : ia;
          sb = (s == 1 && ib >= 8) ? ib - 16 : ib;
          exp = 8'(sa * sb);
          run4(s[0], ia[3:0], ib[3:0], p, lat, bc);
          n_checks++;
          if (p !== exp || lat !== 5) begin
            n_fail++;
            $display("FAIL exh4 s=%0d a=%0d b=%0d got %h lat %0d want %h lat 5", s, ia, ib, p, lat, exp);
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone, lat;
    logic [7:0] p;
    sgn4 = 1'b1; a4 = 4'h3; b4 = 4'hB; start4 = 1'b1;
    step();
    start4 = 1'b0;
    ndone = 0; lat = -1; p = 8'h00;
    for (int i = 1; i <= 15; i++) begin
      // New operands and a start pulse while the operation is running
      if (i == 2) begin a4 = 4'h7; b4 = 4'h7; start4 = 1'b1; end
      else begin start4 = 1'b0; a4 = a4 + 4'h5; b4 = b4 ^ 4'hA; sgn4 = ~sgn4; end
      if (i >= 5) start4 = 1'b0;
      step();
      if (done4) begin
        ndone++;
        if (lat < 0) begin lat = i; p = prod4; end
      end
    end
    start4 = 1'b0;
    n_checks += 3;
    if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    if (lat !== 5) begin n_fail++; $display("FAIL ignore_lat got %0d want 5", lat); end
    if (p !== 8'hF1) begin n_fail++; $display("FAIL ignore_prod got %h want f1", p); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [7:0] p1, p2;
    logic bz;
    sgn4 = 1'b1; a4 = 4'h3; b4 = 4'hB; start4 = 1'b1;
    step();
    a4 = 4'h2; b4 = 4'h3;
    lat1 = -1; p1 = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done4) begin lat1 = i; p1 = prod4; break; end
    end
    // start is still high during the done cycle, so the next edge accepts it
    step();
    start4 = 1'b0;
    bz = busy4;
    lat2 = -1; p2 = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done4) begin lat2 = i; p2 = prod4; break; end
    end
    n_checks += 5;
    if (p1 !== 8'hF1) begin n_fail++; $display("FAIL b2b_prod1 got %h want f1", p1); end
    if (lat1 !== 5) begin n_fail++; $display("FAIL b2b_lat1 got %0d want 5", lat1); end
    if (bz !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b want 1", bz); end
    if (p2 !== 8'h06) begin n_fail++; $display("FAIL b2b_prod2 got %h want 06", p2); end
    if (lat2 !== 5) begin n_fail++; $display("FAIL b2b_lat2 got %0d want 5", lat2); end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bc;
    logic [7:0] p;
    sgn4 = 1'b1; a4 = 4'h3; b4 = 4'hB; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks += 4;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy4); end
    if (done4 !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done4); end
    if (prod4 !== 8'h00) begin n_fail++; $display("FAIL midrst_prod got %h want 00", prod4); end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done4) ndone++;
    end
    if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    run4(1'b1, 4'h7, 4'h8, p, lat, bc);
    n_checks += 2;
    if (p !== 8'hC8) begin n_fail++; $display("FAIL midrst_fresh_prod got %h want c8", p); end
    if (lat !== 5) begin n_fail++; $display("FAIL midrst_fresh_lat got %0d want 5", lat); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start4 = 1'b0; sgn4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    #1;
    test_reset();
    test_latency();
    test_directed4();
    test_width8();
    test_exhaustive4();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
